// File: rtl/rv64i_mem_arbiter.sv
// Shared-memory arbiter for the RV64I pipeline: one grant per cycle, in-order read steering,
// stall generation and halt drain. Optional fetch anti-starvation guard: ARB_STARVE_GUARD_EN.
module rv64i_mem_arbiter #(
  parameter int XLEN       = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [7:0]      dm_wstrb,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  input  logic            halt_req,
  output logic            if_stall,
  output logic            dm_stall,
  output logic            halted,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  // owner: 1 = data port, 0 = fetch port
  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
  } tag_t;

  state_t               state;
  tag_t [MEM_LAT-1:0]   tag_q;
  tag_t                 new_tag;
  tag_t                 tail;
  logic                 fetch_ok, data_ok, starve_hit;
  logic                 if_win, dm_win;
  logic                 inflight, drain_done;

  assign fetch_ok = (state == RUN);
  assign data_ok  = (state != HALT);

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;
  assign starve_hit = (starve_cnt == 8'(STARVE_MAX));

  // Counts consecutive denied fetch cycles; frozen once draining or halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == RUN) begin
      if (if_win || !if_req)
        starve_cnt <= '0;
      else if (starve_cnt != 8'(STARVE_MAX))
        starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (!reset) begin
      if (if_req && fetch_ok && (starve_hit || !(dm_req && data_ok)))
        if_win = 1'b1;
      else if (dm_req && data_ok)
        dm_win = 1'b1;
    end
  end

  assign if_gnt    = if_win;
  assign dm_gnt    = dm_win;
  assign if_stall  = if_req & ~if_win & ~reset;
  assign dm_stall  = dm_req & ~dm_win & ~reset;

  assign mem_en    = if_win | dm_win;
  assign mem_we    = dm_win & dm_we;
  assign mem_addr  = dm_win ? dm_addr : (if_win ? if_addr : '0);
  assign mem_wdata = dm_win ? dm_wdata : '0;
  assign mem_wstrb = dm_win ? dm_wstrb : 8'h00;

  always_comb begin
    new_tag.valid   = mem_en & ~mem_we;
    new_tag.owner   = dm_win;
    new_tag.is_read = mem_en & ~mem_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i < MEM_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail      = tag_q[MEM_LAT-1];
  assign if_rvalid = tail.valid & tail.is_read & ~tail.owner;
  assign dm_rvalid = tail.valid & tail.is_read &  tail.owner;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  // Drain is judged on the pipe contents after this edge, so halted rises
  // on the edge right after the final rvalid cycle.
  always_comb begin
    inflight = new_tag.valid;
    for (int i = 0; i < MEM_LAT - 1; i++)
      inflight = inflight | tag_q[i].valid;
  end

  assign drain_done = ~inflight & ~dm_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN:     if (halt_req) state <= DRAIN;
        DRAIN:   if (drain_done) begin
                   state  <= HALT;
                   halted <= 1'b1;
                 end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64i_mem_arbiter.sv
// Directed bench for rv64i_mem_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_rv64i_mem_arbiter;

  logic        clk, reset;
  logic        if_req, dm_req, dm_we, halt_req;
  logic [63:0] if_addr, dm_addr, dm_wdata;
  logic [7:0]  dm_wstrb;

  logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_if_stall, a_dm_stall, a_halted, a_mem_en, a_mem_we;
  logic [63:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [7:0]  a_mem_wstrb;
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_if_stall, b_dm_stall, b_halted, b_mem_en, b_mem_we;
  logic [63:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_wstrb;

  int checks = 0;
  int errors = 0;

  rv64i_mem_arbiter #(.XLEN(64), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .halt_req(halt_req), .if_stall(a_if_stall), .dm_stall(a_dm_stall), .halted(a_halted),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata)
  );

  rv64i_mem_arbiter #(.XLEN(64), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .halt_req(halt_req), .if_stall(b_if_stall), .dm_stall(b_dm_stall), .halted(b_halted),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at address A reads as A + 0x1000F.
  function automatic logic [63:0] mem_val(input logic [63:0] a);
    return a + 64'h1000F;
  endfunction

  logic [63:0] a_rd_q;
  logic [63:0] b_rd_q [3];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd_q <= '0;
      b_rd_q[0] <= '0; b_rd_q[1] <= '0; b_rd_q[2] <= '0;
    end else begin
      a_rd_q    <= (a_mem_en & ~a_mem_we) ? mem_val(a_mem_addr) : 64'h0;
      b_rd_q[0] <= (b_mem_en & ~b_mem_we) ? mem_val(b_mem_addr) : 64'h0;
      b_rd_q[1] <= b_rd_q[0];
      b_rd_q[2] <= b_rd_q[1];
    end
  end
  assign a_mem_rdata = a_rd_q;
  assign b_mem_rdata = b_rd_q[2];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_wstrb = 0; halt_req = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    if_req = 1; dm_req = 1; if_addr = 64'h4; dm_addr = 64'h100;
    mid();
    checks++; if (a_if_gnt !== 1'b0 || a_dm_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got if=%b dm=%b exp 0 0", a_if_gnt, a_dm_gnt); end
    checks++; if (a_mem_en !== 1'b0 || a_mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem got en=%b addr=%h exp 0", a_mem_en, a_mem_addr); end
    checks++; if (a_if_stall !== 1'b0 || a_dm_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b%b exp 00", a_if_stall, a_dm_stall); end
    checks++; if (a_halted !== 1'b0 || b_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b%b exp 00", a_halted, b_halted); end
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1; if_addr = 64'h4;
    mid();
    checks++; if (a_if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got %b exp 1", a_if_gnt); end
    checks++; if (a_mem_addr !== 64'h4 || a_mem_we !== 1'b0 || a_mem_wstrb !== 8'h0) begin errors++; $display("FAIL fetch_mem got addr=%h we=%b strb=%h exp 4 0 00", a_mem_addr, a_mem_we, a_mem_wstrb); end
    checks++; if (a_if_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall got %b exp 0", a_if_stall); end
    tick(); if_req = 0;
    mid();
    checks++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== 64'h10013) begin errors++; $display("FAIL fetch_rdata got v=%b d=%h exp 1 10013", a_if_rvalid, a_if_rdata); end
    checks++; if (a_dm_rvalid !== 1'b0 || a_dm_rdata !== 64'h0) begin errors++; $display("FAIL fetch_dm_idle got v=%b d=%h exp 0 0", a_dm_rvalid, a_dm_rdata); end
    checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_lat3_early got %b exp 0", b_if_rvalid); end
    tick(); tick(); mid();
    checks++; if (b_if_rvalid !== 1'b1 || b_if_rdata !== 64'h10013) begin errors++; $display("FAIL fetch_lat3 got v=%b d=%h exp 1 10013", b_if_rvalid, b_if_rdata); end
  endtask

  task automatic test_priority();
    do_reset();
    if_req = 1; if_addr = 64'h8; dm_req = 1; dm_we = 0; dm_addr = 64'h100;
    mid();
    checks++; if (a_dm_gnt !== 1'b1 || a_if_gnt !== 1'b0) begin errors++; $display("FAIL prio_gnt got dm=%b if=%b exp 1 0", a_dm_gnt, a_if_gnt); end
    checks++; if (a_if_stall !== 1'b1 || a_dm_stall !== 1'b0) begin errors++; $display("FAIL prio_stall got if=%b dm=%b exp 1 0", a_if_stall, a_dm_stall); end
    checks++; if (a_mem_addr !== 64'h100) begin errors++; $display("FAIL prio_addr got %h exp 100", a_mem_addr); end
    tick(); dm_req = 0;
    mid();
    checks++; if (a_if_gnt !== 1'b1 || a_mem_addr !== 64'h8) begin errors++; $display("FAIL prio_fetch_next got gnt=%b addr=%h exp 1 8", a_if_gnt, a_mem_addr); end
    checks++; if (a_dm_rvalid !== 1'b1 || a_dm_rdata !== 64'h1010F || a_if_rvalid !== 1'b0) begin errors++; $display("FAIL prio_dm_resp got v=%b d=%h ifv=%b exp 1 1010f 0", a_dm_rvalid, a_dm_rdata, a_if_rvalid); end
    tick(); if_req = 0;
    mid();
    checks++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== 64'h10017 || a_dm_rvalid !== 1'b0) begin errors++; $display("FAIL prio_if_resp got v=%b d=%h dmv=%b exp 1 10017 0", a_if_rvalid, a_if_rdata, a_dm_rvalid); end
  endtask

  task automatic test_store();
    int rv;
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 64'h200; dm_wdata = 64'hDEAD; dm_wstrb = 8'h0F;
    mid();
    checks++; if (a_dm_gnt !== 1'b1 || a_mem_en !== 1'b1) begin errors++; $display("FAIL store_gnt got gnt=%b en=%b exp 1 1", a_dm_gnt, a_mem_en); end
    checks++; if (a_mem_we !== 1'b1 || a_mem_wstrb !== 8'h0F || a_mem_wdata !== 64'hDEAD) begin errors++; $display("FAIL store_mem got we=%b strb=%h wd=%h exp 1 0f dead", a_mem_we, a_mem_wstrb, a_mem_wdata); end
    tick(); clear_inputs();
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      rv += int'(a_dm_rvalid) + int'(b_dm_rvalid) + int'(a_if_rvalid) + int'(b_if_rvalid);
      tick();
    end
    checks++; if (rv !== 0) begin errors++; $display("FAIL store_no_rvalid got %0d pulses exp 0", rv); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [3];
    addrs[0] = 64'h0; addrs[1] = 64'h8; addrs[2] = 64'h10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if_req = (i < 3); if_addr = (i < 3) ? addrs[i] : 64'h0;
      mid();
      if (i < 3) begin
        checks++; if (a_if_gnt !== 1'b1 || a_mem_addr !== addrs[i]) begin errors++; $display("FAIL b2b_gnt%0d got gnt=%b addr=%h exp 1 %h", i, a_if_gnt, a_mem_addr, addrs[i]); end
      end
      if (i > 0) begin
        checks++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== mem_val(addrs[i-1])) begin errors++; $display("FAIL b2b_resp%0d got v=%b d=%h exp 1 %h", i, a_if_rvalid, a_if_rdata, mem_val(addrs[i-1])); end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_starve();
    logic [19:0] mask, exp_mask;
    int nf;
    do_reset();
    if_req = 1; if_addr = 64'h40; dm_req = 1; dm_we = 0; dm_addr = 64'h300;
    mask = '0; nf = 0;
    for (int i = 0; i < 20; i++) begin
      mid();
      mask[i] = a_if_gnt;
      nf += int'(a_if_gnt);
      tick();
    end
    clear_inputs();
`ifdef ARB_STARVE_GUARD_EN
    exp_mask = 20'h84210;
`else
    exp_mask = 20'h00000;
`endif
    checks++; if (mask !== exp_mask) begin errors++; $display("FAIL starve_pattern got %h exp %h", mask, exp_mask); end
    checks++; if (nf !== $countones(exp_mask)) begin errors++; $display("FAIL starve_count got %0d exp %0d", nf, $countones(exp_mask)); end
  endtask

  task automatic test_halt();
    int bad;
    do_reset();
    if_req = 1; if_addr = 64'h10;
    mid();
    checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL halt_pre_gnt got %b exp 1", b_if_gnt); end
    tick(); if_req = 0; halt_req = 1;
    tick(); halt_req = 0; if_req = 1; if_addr = 64'h20;
    mid();
    checks++; if (b_if_gnt !== 1'b0 || a_if_gnt !== 1'b0 || b_if_stall !== 1'b1) begin errors++; $display("FAIL halt_no_fetch got b=%b a=%b stall=%b exp 0 0 1", b_if_gnt, a_if_gnt, b_if_stall); end
    checks++; if (b_if_rvalid !== 1'b0 || b_halted !== 1'b0) begin errors++; $display("FAIL halt_early got v=%b h=%b exp 0 0", b_if_rvalid, b_halted); end
    tick(); mid();
    checks++; if (b_if_rvalid !== 1'b1 || b_if_rdata !== 64'h1001F || b_halted !== 1'b0) begin errors++; $display("FAIL halt_drain_resp got v=%b d=%h h=%b exp 1 1001f 0", b_if_rvalid, b_if_rdata, b_halted); end
    tick(); mid();
    checks++; if (b_halted !== 1'b1 || a_halted !== 1'b1) begin errors++; $display("FAIL halt_done got b=%b a=%b exp 1 1", b_halted, a_halted); end
    tick();
    dm_req = 1; dm_addr = 64'h500;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      halt_req = i[0];
      mid();
      if (b_halted !== 1'b1 || a_halted !== 1'b1 || b_if_gnt || b_dm_gnt || a_if_gnt || a_dm_gnt || b_mem_en) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_sticky got %0d bad cycles exp 0", bad); end
    reset = 1'b1; #1;
    checks++; if (b_halted !== 1'b0 || a_halted !== 1'b0) begin errors++; $display("FAIL halt_reset got b=%b a=%b exp 0 0", b_halted, a_halted); end
    do_reset();
  endtask

  task automatic test_reset_midflight();
    int rv;
    do_reset();
    if_req = 1; if_addr = 64'h30;
    tick(); if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 64'h400;
    tick(); dm_req = 0; if_req = 1; reset = 1'b1;
    #1;
    checks++; if ({b_if_gnt, b_if_rvalid, b_if_rdata, b_dm_gnt, b_dm_rvalid, b_dm_rdata, b_if_stall, b_dm_stall,
                   b_halted, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_wstrb} !== '0) begin
      errors++; $display("FAIL midreset_outputs got gnt=%b%b rv=%b%b stall=%b%b en=%b addr=%h exp all 0",
                         b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_if_stall, b_dm_stall, b_mem_en, b_mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0; clear_inputs();
    rv = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      rv += int'(b_if_rvalid) + int'(b_dm_rvalid);
      tick();
    end
    checks++; if (rv !== 0) begin errors++; $display("FAIL midreset_stale_rvalid got %0d exp 0", rv); end
    if_req = 1; if_addr = 64'h50;
    mid();
    checks++; if (b_if_gnt !== 1'b1 || b_halted !== 1'b0) begin errors++; $display("FAIL midreset_run got gnt=%b h=%b exp 1 0", b_if_gnt, b_halted); end
    tick(); clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_back_to_back();
    test_starve();
    test_halt();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
